irq_controller: RTL and testbench

- External-interrupt controller that sits directly upstream of the core's CSR/trap unit.
- Collects NUM_SRC peripheral interrupt lines, masks and prioritises them, and drives the single meip line.
- Consumes the core's one-cycle irq_ack pulse as the claim event, then holds off further meip until software signals completion.
- Software accesses it through a small memory-mapped register port on the data bus.

---
 rtl/irq_controller.sv | 131 +++++++++++++
 tb/tb_irq_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: masks and prioritises NUM_SRC interrupt lines into one meip line,
// takes irq_ack as the claim and holds meip low until software writes COMPLETE.
// Ports: clk/reset, irq_src/irq_ack/meip (core side), bus_* register port, claim_valid.
module irq_controller #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               irq_ack,
   output logic               meip,
   input  logic [4:0]         bus_addr,
   input  logic [31:0]        bus_wdata,
   input  logic               bus_we,
   input  logic               bus_re,
   output logic [31:0]        bus_rdata,
   output logic               claim_valid
);

   localparam logic [2:0] A_ENABLE   = 3'd0;
   localparam logic [2:0] A_PENDING  = 3'd1;
   localparam logic [2:0] A_TRIGGER  = 3'd2;
   localparam logic [2:0] A_CLAIM    = 3'd3;
   localparam logic [2:0] A_COMPLETE = 3'd4;

   typedef enum logic [1:0] {IDLE, ASSERT, CLAIMED} state_t;

   state_t             state, state_nxt;
   logic [NUM_SRC-1:0] enable, trigger, pending, src_d;
   logic [NUM_SRC-1:0] eligible, set_vec, clr_vec;
   logic [ID_W-1:0]    claim_id, winner;
   logic [2:0]         sel;
   logic               any_elig, claim_fire, complete_hit;
   logic [31:0]        rd_val;

   // Byte-offset bits and upper write-data bits carry no meaning here.
   logic               unused_bits;
   assign unused_bits = ^{bus_addr[1:0], bus_wdata};

   assign sel      = bus_addr[4:2];
   assign eligible = pending & enable;
   assign any_elig = |eligible;

   // Lowest index wins: scan downwards so the last hit is the smallest index.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   assign claim_fire   = (state == ASSERT) && any_elig && irq_ack;
   assign complete_hit = bus_we && (sel == A_COMPLETE) &&
                         (bus_wdata[ID_W-1:0] == claim_id);

   // Set/clear vectors. A level source that is currently claimed cannot
   // re-pend itself until completion, otherwise it would be claimed twice.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (trigger[i])
            set_vec[i] = irq_src[i] & ~src_d[i];
         else
            set_vec[i] = irq_src[i] &
                         ~((state == CLAIMED) && (claim_id == ID_W'(i)));
         clr_vec[i] = claim_fire && (winner == ID_W'(i));
      end
   end

   // Register read mux; bits at or above NUM_SRC are zero by extension.
   always_comb begin
      rd_val = '0;
      case (sel)
         A_ENABLE:  rd_val = 32'(enable);
         A_PENDING: rd_val = 32'(pending);
         A_TRIGGER: rd_val = 32'(trigger);
         A_CLAIM:   rd_val = {claim_valid, {(31-ID_W){1'b0}}, claim_id};
         default:   rd_val = '0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_elig) state_nxt = ASSERT;
         ASSERT: begin
            // Losing eligibility takes precedence: there is nothing to claim.
            if (!any_elig)    state_nxt = IDLE;
            else if (irq_ack) state_nxt = CLAIMED;
         end
         CLAIMED: if (complete_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      meip        = (state == ASSERT);
      claim_valid = (state == CLAIMED);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         enable    <= '0;
         trigger   <= '0;
         pending   <= '0;
         src_d     <= '0;
         claim_id  <= '0;
         bus_rdata <= '0;
      end else begin
         src_d   <= irq_src;
         // Set wins over the claim clear on the same bit.
         pending <= (pending & ~clr_vec) | set_vec;
         if (claim_fire) claim_id <= winner;
         if (bus_we && (sel == A_ENABLE))  enable  <= bus_wdata[NUM_SRC-1:0];
         if (bus_we && (sel == A_TRIGGER)) trigger <= bus_wdata[NUM_SRC-1:0];
         if (bus_re) bus_rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus random traffic against a
// behavioural model; expected outputs are queued per cycle and a separate
// monitor compares meip, claim_valid and bus_rdata after each edge.
module tb_irq_controller;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NUM_SRC-1:0] irq_src = '0;
   logic               irq_ack = 1'b0;
   logic               meip;
   logic [4:0]         bus_addr = '0;
   logic [31:0]        bus_wdata = '0;
   logic               bus_we = 1'b0;
   logic               bus_re = 1'b0;
   logic [31:0]        bus_rdata;
   logic               claim_valid;

   irq_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .irq_ack(irq_ack),
      .meip(meip), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
      .claim_valid(claim_valid)
   );

   always #5 clk = ~clk;

   // ---------------- stimulus variables ----------------
   bit               rst_v = 1'b1;
   bit [NUM_SRC-1:0] src_v = '0;
   bit               ack_v, we_v, re_v;
   bit [4:0]         addr_v;
   bit [31:0]        wd_v;

   // ---------------- reference model ----------------
   // mode: 0 = nothing signalled, 1 = meip raised, 2 = claim outstanding
   localparam bit [31:0] SRC_MASK = (32'd1 << NUM_SRC) - 32'd1;
   localparam bit [31:0] ID_MASK  = (32'd1 << ID_W) - 32'd1;
   bit [31:0] m_en, m_trig, m_pend, m_prev, m_rdata;
   int        m_mode, m_cid;

   typedef struct {
      bit          meip;
      bit          cv;
      logic [31:0] rd;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   function automatic int lowest(bit [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit [31:0] reg_read(bit [4:0] a);
      case (a >> 2)
         0: return m_en;
         1: return m_pend;
         2: return m_trig;
         3: return ((m_mode == 2) ? 32'h8000_0000 : 32'h0) | 32'(m_cid);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model();
      bit [31:0] elig, setv, pend_n;
      int        w, mode_n, word;
      exp_t      e;
      if (rst_v) begin
         m_en = 0; m_trig = 0; m_pend = 0; m_prev = 0; m_rdata = 0;
         m_mode = 0; m_cid = 0;
      end else begin
         elig = m_pend & m_en;
         w    = lowest(elig);
         word = int'(addr_v >> 2);
         if (re_v) m_rdata = reg_read(addr_v);
         setv = 0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (m_trig[i]) setv[i] = src_v[i] && !m_prev[i];
            else           setv[i] = src_v[i] && !(m_mode == 2 && m_cid == i);
         end
         pend_n = m_pend;
         mode_n = m_mode;
         if (m_mode == 0) begin
            if (elig != 0) mode_n = 1;
         end else if (m_mode == 1) begin
            if (elig == 0) mode_n = 0;
            else if (ack_v) begin
               mode_n = 2;
               m_cid  = w;
               pend_n[w] = 1'b0;
            end
         end else begin
            if (we_v && word == 4 && (wd_v & ID_MASK) == 32'(m_cid)) mode_n = 0;
         end
         m_pend = pend_n | setv;
         m_mode = mode_n;
         if (we_v && word == 0) m_en   = wd_v & SRC_MASK;
         if (we_v && word == 2) m_trig = wd_v & SRC_MASK;
         m_prev = 32'(src_v);
      end
      e.meip = (m_mode == 1);
      e.cv   = (m_mode == 2);
      e.rd   = m_rdata;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus: drive on the falling edge, predict, drop strobes.
   task automatic step();
      @(negedge clk);
      reset     = rst_v;
      irq_src   = src_v;
      irq_ack   = ack_v;
      bus_addr  = addr_v;
      bus_wdata = wd_v;
      bus_we    = we_v;
      bus_re    = re_v;
      model();
      ack_v = 0; we_v = 0; re_v = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wr(input bit [4:0] a, input bit [31:0] d);
      addr_v = a; wd_v = d; we_v = 1; step();
   endtask

   task automatic rd(input bit [4:0] a);
      addr_v = a; re_v = 1; step();
   endtask

   // Ack as soon as the model says meip is up (bounded).
   task automatic ack_when_up();
      for (int k = 0; k < 8; k++) begin
         if (m_mode == 1) begin
            ack_v = 1; step(); return;
         end
         step();
      end
   endtask

   // ---------------- monitor ----------------
   exp_t e_mon;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         total++;
         if (meip !== e_mon.meip) begin
            bad++;
            $display("FAIL meip t=%0t got=%b want=%b", $time, meip, e_mon.meip);
         end
         total++;
         if (claim_valid !== e_mon.cv) begin
            bad++;
            $display("FAIL claim_valid t=%0t got=%b want=%b", $time, claim_valid, e_mon.cv);
         end
         total++;
         if (bus_rdata !== e_mon.rd) begin
            bad++;
            $display("FAIL bus_rdata t=%0t got=%h want=%h", $time, bus_rdata, e_mon.rd);
         end
      end
   end

   // ---------------- scenarios ----------------
   initial begin
      int r;
      rst_v = 1; idle(3); rst_v = 0;
      rd(5'h00); rd(5'h0C);

      // Level source 0: claim, complete, re-assert while still high.
      wr(5'h00, 32'h1);
      src_v = 8'h01; idle(2);
      ack_when_up(); rd(5'h0C);
      wr(5'h10, 32'h0); idle(3);
      src_v = 8'h00; ack_when_up(); idle(1);
      wr(5'h10, 32'h0); idle(2);

      // Simultaneous edges on 5 and 2: 2 first, then 5.
      wr(5'h00, 32'hFF); wr(5'h08, 32'hFF);
      src_v = 8'h24; step(); src_v = 8'h00;
      ack_when_up(); rd(5'h0C); rd(5'h04);
      wr(5'h10, 32'h2); ack_when_up(); rd(5'h0C); rd(5'h04);
      wr(5'h10, 32'h5); idle(2);

      // Mismatching completion is ignored.
      src_v = 8'h08; step(); src_v = 8'h00;
      ack_when_up(); wr(5'h10, 32'h4); rd(5'h0C); idle(2);
      wr(5'h10, 32'h3); rd(5'h0C); idle(2);

      // Enable dropped while asserted; a late ack does nothing.
      wr(5'h08, 32'h0); wr(5'h00, 32'h1); src_v = 8'h01;
      for (int k = 0; k < 6 && m_mode != 1; k++) step();
      wr(5'h00, 32'h0); step(); ack_v = 1; step(); rd(5'h0C);
      src_v = 8'h00; idle(2);

      // Edge on source 1 re-fires on the claim cycle: pending bit survives.
      wr(5'h00, 32'hFF); wr(5'h08, 32'hFF); rd(5'h04);
      src_v = 8'h02; step(); src_v = 8'h00; step();
      for (int k = 0; k < 6 && m_mode != 1; k++) step();
      src_v = 8'h02; ack_v = 1; step(); src_v = 8'h00;
      rd(5'h04); rd(5'h0C); wr(5'h10, 32'h1); idle(2);

      // Reset while claimed with pending 0x0C.
      ack_when_up(); idle(1); rd(5'h04);
      src_v = 8'h0C; step(); src_v = 8'h00; step(); rd(5'h04); rd(5'h0C);
      rst_v = 1; step(); rst_v = 0;
      rd(5'h00); rd(5'h04); rd(5'h08); rd(5'h0C);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 4) == 0) src_v = NUM_SRC'($urandom);
         ack_v = ($urandom_range(0, 9) < ((m_mode == 1) ? 5 : 1));
         r = $urandom_range(0, 9);
         addr_v = 5'($urandom);
         if (r < 3) re_v = 1;
         else if (r == 3) begin addr_v = {3'd0, 2'($urandom)}; wd_v = $urandom; we_v = 1; end
         else if (r == 4) begin addr_v = {3'd2, 2'($urandom)}; wd_v = $urandom; we_v = 1; end
         else if (r < 7) begin
            addr_v = {3'd4, 2'($urandom)};
            wd_v = ($urandom_range(0, 1) != 0) ? (32'(m_cid) | ($urandom & ~ID_MASK)) : $urandom;
            we_v = 1;
         end
         rst_v = ($urandom_range(0, 299) == 0);
         step();
      end
      rst_v = 0; idle(2);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
